// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the MIPS data-memory path.
package mips_mem_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int BYTE_OFF_W = 2;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write, registered read and async active-low clear.
module dmem_array
   import mips_mem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic              clr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (we) mem[idx] <= wdata;
         if (re) rdata <= mem[idx];
         else if (clr) rdata <= '0;
      end
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder with valid/ready request and response channels.
// Optional misaligned-access error reporting is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
   import mips_mem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   dmem_state_t state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic armed, req_fire, resp_fire, acc_go, acc_write, acc_err, mis;
   logic lat_write, lat_err;
   logic [IDX_W-1:0] lat_idx, req_idx, acc_idx;
   logic [DATA_W-1:0] lat_wdata, acc_wdata;
   logic unused_addr;
`ifdef DMEM_ALIGN_CHECK_EN
   assign mis = |req_addr[BYTE_OFF_W-1:0];
`else
   assign mis = 1'b0;
`endif
   assign unused_addr = ^{req_addr[31:IDX_W+BYTE_OFF_W], req_addr[BYTE_OFF_W-1:0]};
   assign req_idx    = req_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
   // armed holds req_ready low until the first clock after reset release
   assign req_ready  = armed && state == IDLE;
   assign req_fire   = req_valid && req_ready;
   assign resp_valid = state == RESP;
   assign resp_fire  = resp_valid && resp_ready;
   // zero-wait accesses use the live request; otherwise the latched copy
   assign acc_write  = state == IDLE ? req_write : lat_write;
   assign acc_err    = state == IDLE ? mis : lat_err;
   assign acc_idx    = state == IDLE ? req_idx : lat_idx;
   assign acc_wdata  = state == IDLE ? req_wdata : lat_wdata;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      acc_go   = 1'b0;
      case (state)
         IDLE: if (req_fire) begin
            state_nx = WAIT_CYCLES == 0 ? RESP : WAIT;
            cnt_nx   = CNT_INIT;
            acc_go   = WAIT_CYCLES == 0;
         end
         WAIT: begin
            cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            state_nx = cnt == 4'd0 ? RESP : WAIT;
            acc_go   = cnt == 4'd0;
         end
         RESP: state_nx = resp_fire ? IDLE : RESP;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         armed     <= 1'b0;
         lat_write <= 1'b0;
         lat_err   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         resp_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         armed    <= 1'b1;
         resp_err <= acc_go ? acc_err : resp_fire ? 1'b0 : resp_err;
         if (req_fire) begin
            lat_write <= req_write;
            lat_err   <= mis;
            lat_idx   <= req_idx;
            lat_wdata <= req_wdata;
         end
      end
   end
   dmem_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (acc_go && acc_write && !acc_err),
      .re    (acc_go && !acc_write && !acc_err),
      .clr   (acc_go || resp_fire),
      .idx   (acc_idx),
      .wdata (acc_wdata),
      .rdata (resp_rdata)
   );
endmodule
